// File: rtl/mult_parity_seq.sv
// Sequential signed multiplier with parity-checked operands.
// One shift-add step per cycle over operand magnitudes, sign applied at the end.
module mult_parity_seq #(
  parameter int DATA_W     = 16,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [DATA_W-1:0]     arg_a,
  input  logic                  arg_a_parity,
  input  logic [DATA_W-1:0]     arg_b,
  input  logic                  arg_b_parity,
  output logic                  ack,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_parity,
  output logic                  arg_parity_error,
  output logic                  result_rdy
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mag_a_q, mag_a_d;
  logic [DATA_W-1:0] mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic              ack_q, ack_d;
  logic              rdy_q, rdy_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              res_par_q, res_par_d;
  logic              perr_q, perr_d;

  logic              last;
  logic              a_bad;
  logic              b_bad;
  logic [RES_W-1:0]  pp;
  logic [RES_W-1:0]  acc_sum;
  logic [RES_W-1:0]  prod;

  function automatic logic par_of(input logic [RES_W-1:0] v);
    return (^v) ^ ODD_PARITY;
  endfunction

  assign last    = (cnt_q == CNT_W'(DATA_W - 1));
  assign a_bad   = arg_a_parity != par_of(RES_W'(arg_a));
  assign b_bad   = arg_b_parity != par_of(RES_W'(arg_b));
  assign pp      = mag_b_q[cnt_q] ? (RES_W'(mag_a_q) << cnt_q) : '0;
  assign acc_sum = acc_q + pp;
  assign prod    = neg_q ? (~acc_sum + RES_W'(1)) : acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = ACK;
      ACK:  state_d = err_q ? DONE : CALC;
      CALC: if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Normal path registers the result as DONE is entered; the error
  // path skips CALC and registers it on the way out of DONE.
  always_comb begin
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ack_d     = 1'b0;
    rdy_d     = 1'b0;
    result_d  = result_q;
    res_par_d = res_par_q;
    perr_d    = perr_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          mag_a_d = arg_a[DATA_W-1] ? (~arg_a + DATA_W'(1)) : arg_a;
          mag_b_d = arg_b[DATA_W-1] ? (~arg_b + DATA_W'(1)) : arg_b;
          neg_d   = arg_a[DATA_W-1] ^ arg_b[DATA_W-1];
          err_d   = a_bad | b_bad;
          ack_d   = 1'b1;
        end
      end
      ACK: begin
        cnt_d = '0;
        acc_d = '0;
      end
      CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          result_d  = prod;
          res_par_d = par_of(prod);
          perr_d    = 1'b0;
          rdy_d     = 1'b1;
        end
      end
      DONE: begin
        if (err_q) begin
          result_d  = '0;
          res_par_d = par_of('0);
          perr_d    = 1'b1;
          rdy_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ack_q     <= 1'b0;
      rdy_q     <= 1'b0;
      result_q  <= '0;
      res_par_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ack_q     <= ack_d;
      rdy_q     <= rdy_d;
      result_q  <= result_d;
      res_par_q <= res_par_d;
      perr_q    <= perr_d;
    end
  end

  assign ack              = ack_q;
  assign result_rdy       = rdy_q;
  assign result           = result_q;
  assign result_parity    = res_par_q;
  assign arg_parity_error = perr_q;

endmodule

// File: tb/tb_mult_parity_seq.sv
// Randomized self-checking bench for mult_parity_seq.
// Expected values come from plain signed arithmetic and parity rules.
module tb_mult_parity_seq;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [15:0] arg_a;
  logic        arg_a_parity;
  logic [15:0] arg_b;
  logic        arg_b_parity;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        arg_parity_error;
  logic        result_rdy;

  int n_chk;
  int n_pass;

  mult_parity_seq #(
    .DATA_W     (16),
    .ODD_PARITY (1'b0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .arg_parity_error (arg_parity_error),
    .result_rdy       (result_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic par16(input logic [15:0] v);
    return ^v;
  endfunction

  function automatic logic par32(input logic [31:0] v);
    return ^v;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_txn(input logic [15:0] a, input logic ap,
                         input logic [15:0] b, input logic bp);
    logic        err;
    logic [31:0] exp_res;
    int          sa, sb, lat, exp_lat;
    bit          seen;
    sa      = $signed(a);
    sb      = $signed(b);
    err     = (ap != par16(a)) || (bp != par16(b));
    exp_res = err ? 32'h0 : 32'(sa * sb);
    exp_lat = err ? 2 : 17;
    @(negedge clk);
    req = 1'b1; arg_a = a; arg_a_parity = ap;
    arg_b = b; arg_b_parity = bp;
    @(posedge clk); #1;
    chk("ack_rise", 32'(ack), 32'd1);
    @(negedge clk);
    req = 1'b0;
    arg_a = 16'($urandom); arg_b = 16'($urandom);
    arg_a_parity = 1'($urandom); arg_b_parity = 1'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (n == 1) chk("ack_fall", 32'(ack), 32'd0);
      if (result_rdy) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    chk("rdy_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", result, exp_res);
    chk("res_parity", 32'(result_parity), 32'(par32(exp_res)));
    chk("perr", 32'(arg_parity_error), 32'(err));
    @(posedge clk); #1;
    chk("rdy_pulse", 32'(result_rdy), 32'd0);
    chk("hold_result", result, exp_res);
  endtask

  initial begin
    int acks, rdys, last_ack, cnt;
    bit prev_ack, stop;
    logic [15:0] ra, rb;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    req = 1'b0;
    arg_a = '0; arg_b = '0;
    arg_a_parity = 1'b0; arg_b_parity = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdy", 32'(result_rdy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_par", 32'(result_parity), 32'd0);
    chk("rst_perr", 32'(arg_parity_error), 32'd0);

    run_txn(16'd3, 1'b0, 16'hFFFB, 1'b1);
    run_txn(16'h8000, 1'b1, 16'h8000, 1'b1);
    run_txn(16'd1, 1'b0, 16'd2, 1'b1);
    run_txn(16'h0000, 1'b0, 16'h00FF, 1'b0);
    run_txn(16'h7FFF, 1'b1, 16'h8000, 1'b0);

    // reset in the middle of CALC
    @(negedge clk);
    req = 1'b1; arg_a = 16'h1234; arg_a_parity = par16(16'h1234);
    arg_b = 16'h0100; arg_b_parity = par16(16'h0100);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_rdy", 32'(result_rdy), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_par", 32'(result_parity), 32'd0);
    chk("arst_perr", 32'(arg_parity_error), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (result_rdy || ack) cnt++;
    end
    chk("arst_quiet", 32'(cnt), 32'd0);
    run_txn(16'd7, 1'b1, 16'd6, 1'b0);

    // back-to-back with req held high
    @(negedge clk);
    req = 1'b1; arg_a = 16'h7FFF; arg_a_parity = 1'b1;
    arg_b = 16'h7FFF; arg_b_parity = 1'b1;
    acks = 0; rdys = 0; last_ack = 0;
    prev_ack = 1'b0; stop = 1'b0;
    for (int c = 0; c < 90 && !stop; c++) begin
      @(posedge clk); #1;
      if (prev_ack) chk("b2b_ack_fall", 32'(ack), 32'd0);
      if (ack) begin
        if (acks > 0) chk("b2b_spacing", 32'(c - last_ack), 32'd19);
        last_ack = c;
        acks++;
      end
      prev_ack = ack;
      if (result_rdy) begin
        chk("b2b_result", result, 32'h3FFF0001);
        chk("b2b_par", 32'(result_parity), 32'd1);
        chk("b2b_excl", 32'(ack), 32'd0);
        rdys++;
        if (rdys == 3) stop = 1'b1;
      end
    end
    @(negedge clk);
    req = 1'b0;
    chk("b2b_acks", 32'(acks), 32'd3);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 3) ra = 16'h8000;
      if (i == 5) rb = 16'h0000;
      run_txn(ra, par16(ra) ^ ($urandom_range(0, 3) == 0),
              rb, par16(rb) ^ ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
